// File: rtl/keypad_emulator_if.sv
// Keystroke request plus keypad matrix signals between a scanner-side driver and the keypad emulator.
interface keypad_emulator_if;
  logic [3:0]  key_code;
  logic [15:0] hold_cycles;
  logic        press;
  logic [3:0]  columns;
  logic [3:0]  rows;
  logic        busy;
  logic        key_down;
  logic [7:0]  scan_hits;

  modport master (
    output key_code, hold_cycles, press, columns,
    input  rows, busy, key_down, scan_hits
  );

  modport slave (
    input  key_code, hold_cycles, press, columns,
    output rows, busy, key_down, scan_hits
  );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: answers active-low column strobes with active-low rows for one held key.
// Contact bounce on press/release is compiled in only when KEYPAD_EMU_BOUNCE_EN is defined.
//
// state      | meaning
// IDLE       | no contact, waiting for a press
// BOUNCE_IN  | closed/open bounce pairs on press
// HELD       | stable contact for the latched hold count
// BOUNCE_OUT | closed/open bounce pairs on release
module keypad_emulator #(
  parameter int unsigned BouncePairs = 3,
  parameter int unsigned BounceHalf  = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  keypad_emulator_if.slave io_kp
);

  typedef enum logic [1:0] {IDLE, BOUNCE_IN, HELD, BOUNCE_OUT} state_t;

  state_t      r_state;
  logic [1:0]  r_row;
  logic [1:0]  r_col;
  logic [15:0] r_cnt;
  logic [3:0]  r_col_prev;
  logic [3:0]  r_rows;
  logic        r_busy;
  logic        r_key_down;
  logic [7:0]  r_hits;

  logic        w_closed;
  logic        w_strobe;
  logic [15:0] w_hold_m1;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [15:0] HalfM1  = 16'(BounceHalf - 1);
  localparam logic [15:0] PairsM1 = (BouncePairs == 0) ? 16'd0 : 16'(BouncePairs - 1);

  logic [15:0] r_hold_m1;
  logic [15:0] r_pairs;
  logic        r_open;
  logic        w_bounce_done;

  // Last cycle of the last open phase, or immediately when no pairs are configured.
  assign w_bounce_done = (BouncePairs == 0) ||
                         (r_open && (r_cnt == 16'd0) && (r_pairs == 16'd0));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ((BouncePairs + BounceHalf) != 0);
`endif

  assign w_hold_m1 = (io_kp.hold_cycles == 16'd0) ? 16'd0 : io_kp.hold_cycles - 16'd1;
  assign w_strobe  = r_col_prev[r_col] & ~io_kp.columns[r_col];

  always_comb begin
    w_closed = 1'b0;
    case (r_state)
      HELD:       w_closed = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
      BOUNCE_IN,
      BOUNCE_OUT: w_closed = (BouncePairs != 0) && !r_open;
`endif
      default:    w_closed = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_row      <= 2'd0;
      r_col      <= 2'd0;
      r_cnt      <= 16'd0;
      r_col_prev <= 4'b1111;
      r_rows     <= 4'b1111;
      r_busy     <= 1'b0;
      r_key_down <= 1'b0;
      r_hits     <= 8'd0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      r_hold_m1  <= 16'd0;
      r_pairs    <= 16'd0;
      r_open     <= 1'b0;
`endif
    end else begin
      r_col_prev <= io_kp.columns;
      r_rows     <= 4'b1111;
      if (w_closed && !io_kp.columns[r_col]) r_rows[r_row] <= 1'b0;

      if ((r_state == HELD) && w_strobe && (r_hits != 8'hFF)) r_hits <= r_hits + 8'd1;

      case (r_state)
        IDLE: begin
          if (io_kp.press) begin
            r_row  <= io_kp.key_code[3:2];
            r_col  <= io_kp.key_code[1:0];
            r_hits <= 8'd0;
            r_busy <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            r_hold_m1 <= w_hold_m1;
            r_state   <= BOUNCE_IN;
            r_cnt     <= HalfM1;
            r_pairs   <= PairsM1;
            r_open    <= 1'b0;
`else
            r_state    <= HELD;
            r_key_down <= 1'b1;
            r_cnt      <= w_hold_m1;
`endif
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        BOUNCE_IN, BOUNCE_OUT: begin
          if (w_bounce_done) begin
            if (r_state == BOUNCE_IN) begin
              r_state    <= HELD;
              r_key_down <= 1'b1;
              r_cnt      <= r_hold_m1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else if (r_cnt == 16'd0) begin
            r_cnt  <= HalfM1;
            r_open <= ~r_open;
            if (r_open) r_pairs <= r_pairs - 16'd1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        HELD: begin
          if (r_cnt == 16'd0) begin
            r_key_down <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            r_state <= BOUNCE_OUT;
            r_cnt   <= HalfM1;
            r_pairs <= PairsM1;
            r_open  <= 1'b0;
`else
            r_state <= IDLE;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_kp.rows      = r_rows;
  assign io_kp.busy      = r_busy;
  assign io_kp.key_down  = r_key_down;
  assign io_kp.scan_hits = r_hits;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: per-cycle contact model plus busy-length/hit-count scoreboard.
module tb_keypad_emulator;

  localparam int P = 3;
  localparam int H = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int B = (P == 0) ? 1 : 2 * P * H;
`else
  localparam int B = 0;
`endif

  typedef struct {
    int len;
    int hits;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   cyc;
  int   mon_len;
  exp_t sb[$];

  keypad_emulator_if kp();

  keypad_emulator #(.BouncePairs(P), .BounceHalf(H)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_kp (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit contact(input int k, input int hm);
    if (k < B) return (P != 0) && (((k / H) % 2) == 0);
    if (k < B + hm) return 1'b1;
    return (P != 0) && ((((k - B - hm) / H) % 2) == 0);
  endfunction

  // Scoreboard side: measures each busy window and compares it with the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) mon_len = 0;
    else if (kp.busy === 1'b1) mon_len++;
    else if (mon_len != 0) begin
      if (sb.size() == 0) check("sb_entry", 32'd0, 32'd1);
      else begin
        e = sb.pop_front();
        check("busy_len", 32'(mon_len), 32'(e.len));
        check("hits_exit", 32'(kp.scan_hits), 32'(e.hits));
      end
      mon_len = 0;
    end
  end

  // mode 0: fixed columns, 1: rotating one-cold every 4 clocks, 2: random
  task automatic key_stroke(input logic [3:0] code, input int hold, input int mode,
                            input logic [3:0] fixed_cols, input int abort_k, input int interfere_k);
    int         hm, len, exp_hits;
    logic [1:0] r, c;
    logic [3:0] cols, prev_cols, exp_rows;
    exp_t       e;
    hm  = (hold == 0) ? 1 : hold;
    len = 2 * B + hm;
    r   = code[3:2];
    c   = code[1:0];
    kp.key_code    = code;
    kp.hold_cycles = hold[15:0];
    kp.press       = 1'b1;
    prev_cols      = kp.columns;
    e.len  = len;
    e.hits = 0;
    sb.push_back(e);
    exp_hits = 0;
    exp_rows = 4'b1111;
    tick();
    kp.press = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (k == abort_k) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_rows", 32'(kp.rows), 32'hF);
        check("rst_busy", 32'(kp.busy), 32'd0);
        check("rst_hits", 32'(kp.scan_hits), 32'd0);
        check("rst_keydown", 32'(kp.key_down), 32'd0);
        sb.delete();
        return;
      end
      check("busy", 32'(kp.busy), 32'(k < len));
      check("key_down", 32'(kp.key_down), 32'((k >= B) && (k < B + hm)));
      check("rows", 32'(kp.rows), 32'(exp_rows));
      check("hits", 32'(kp.scan_hits), 32'(exp_hits));
      if (k == len) break;
      case (mode)
        0:       cols = fixed_cols;
        1:       cols = ~(4'b0001 << ((cyc / 4) % 4));
        default: cols = 4'($urandom_range(0, 15));
      endcase
      kp.columns = cols;
      if (k == interfere_k) begin
        kp.press       = 1'b1;
        kp.key_code    = ~code;
        kp.hold_cycles = 16'd3;
      end else begin
        kp.press = 1'b0;
      end
      exp_rows = 4'b1111;
      if (contact(k, hm) && !cols[c]) exp_rows[r] = 1'b0;
      if ((k >= B) && (k < B + hm) && prev_cols[c] && !cols[c] && (exp_hits < 255)) exp_hits++;
      if (sb.size() != 0) sb[sb.size() - 1].hits = exp_hits;
      prev_cols = cols;
      tick();
    end
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    cyc            = 0;
    mon_len        = 0;
    rst            = 1'b1;
    kp.columns     = 4'b0000;
    kp.press       = 1'b1;
    kp.key_code    = 4'b1001;
    kp.hold_cycles = 16'd10;

    // Reset wins over a simultaneous press, with all columns strobed.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_rows", 32'(kp.rows), 32'hF);
      check("rst_busy", 32'(kp.busy), 32'd0);
      check("rst_hits", 32'(kp.scan_hits), 32'd0);
    end
    kp.press = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_rows", 32'(kp.rows), 32'hF);
      check("idle_busy", 32'(kp.busy), 32'd0);
      check("idle_hits", 32'(kp.scan_hits), 32'd0);
    end

    key_stroke(4'b1001, 10, 0, 4'b1101, -1, -1);
    key_stroke(4'b0011, 64, 1, 4'b1111, -1, -1);
    check("rot_hits", 32'(kp.scan_hits), 32'd4);
    key_stroke(4'b0110, 12, 2, 4'b1111, -1, 5);
    key_stroke(4'b1111, 0, 0, 4'b0000, -1, -1);
    key_stroke(4'b0100, 40, 2, 4'b1111, B + 5, -1);
    key_stroke(4'b1010, 20, 0, 4'b0000, -1, -1);
    key_stroke(4'b0001, 1500, 2, 4'b1111, -1, -1);
    check("hits_sat", 32'(kp.scan_hits), 32'd255);

    kp.columns = 4'b1111;
    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Behavioural-synthesizable 4x4 matrix keypad emulator: the responder end of the keypad scan interface. It watches the active-low column strobes driven by a keypad scanner and drives the active-low row lines exactly as a physical keypad would with one key held. Contact bounce on press and release is optional. The block sits in benches and loopback builds in place of the physical keypad, with `Columns`/`Rows` wired straight to the scanner and the 7-segment controller. A single `Press` pulse then produces a complete, repeatable keystroke.

## Interface
- `BouncePairs`, default 3: closed/open bounce pairs emitted on press and on release.
- `BounceHalf`, default 4: clock cycles per bounce phase (closed or open); minimum 1.
- `ClockIn`  in  1: system clock; all logic on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `KeyCode`  in  4: key to press; `[3:2]` is the row index, `[1:0]` the column index; sampled on Press acceptance.
- `HoldCycles`  in  16: stable-closed duration in clocks; sampled on Press acceptance; 0 is treated as 1.
- `Press`  in  1: keystroke request; accepted only when `Busy`=0; ignored otherwise.
- `Columns`  in  4: scanner column strobes, active-low; each bit is evaluated independently and need not be one-cold.
- `Rows`  out  4: row returns, active-low; 4'b1111 when no contact.
- `Busy`  out  1: keystroke in progress.
- `KeyDown`  out  1: high only in HELD (stable contact).
- `ScanHits`  out  8: saturating count of strobes of the key's column seen during HELD.

## Operation
- States: IDLE, BOUNCE_IN, HELD, BOUNCE_OUT.
- IDLE:
  - On `Press`=1, latch `KeyCode` into row r / column c and latch max(`HoldCycles`,1).
  - Clear `ScanHits` and go to BOUNCE_IN.
- BOUNCE_IN and BOUNCE_OUT:
  - Each state lasts 2·BouncePairs·BounceHalf cycles.
  - The contact is closed for BounceHalf cycles, then open for BounceHalf, repeated BouncePairs times.
  - BOUNCE_IN goes to HELD; BOUNCE_OUT goes to IDLE.
- HELD:
  - Contact closed for the latched hold count, then go to BOUNCE_OUT.
- Contact map, recomputed every cycle:
  - Next `Rows` = 4'b1111 except bit r = 0, when contact is closed and `Columns[c]`=0.
  - All other `Columns` bits are ignored.
- `Columns` is registered once internally as `ColPrev`.
  - A strobe is `ColPrev[c]`=1 and `Columns[c]`=0.
  - `ScanHits` increments on each strobe while in HELD and saturates at 255.
- `Busy` = (state ≠ IDLE). `KeyDown` = (state = HELD).
- Simultaneous `Press` and `Reset`: `Reset` wins and the Press is discarded.

## Timing
- Reset values: `Rows`=4'b1111, `Busy`=0, `KeyDown`=0, `ScanHits`=0, `ColPrev`=4'b1111, state IDLE.
- Reset mid-keystroke: outputs take the reset values on the next edge and the keystroke is abandoned.
- `Press` sampled high at edge T: `Busy`=1 from T+1, and the first bounce phase begins at T+1.
- `Rows` is registered: one-cycle latency from `Columns`/contact to `Rows`. The scanner must hold each column for at least 2 clocks before sampling.
- Total `Busy` duration = 4·BouncePairs·BounceHalf + max(`HoldCycles`,1) cycles. With the defaults and `HoldCycles`=10, that is 58 cycles.
- `Busy` falls on the same edge as the state returns to IDLE. A `Press` in that first IDLE cycle is accepted; there are no dead cycles between keystrokes.
- Phase and hold counters are 16-bit and do not wrap. HoldCycles=16'hFFFF is honoured exactly.

## Configuration
- `KEYPAD_EMU_BOUNCE_EN` defined:
  - Bounce states are present as described.
  - `BouncePairs`=0 degenerates to zero-length bounce states, each passed through in 1 cycle.
- `KEYPAD_EMU_BOUNCE_EN` undefined:
  - BOUNCE_IN and BOUNCE_OUT are not compiled.
  - IDLE goes directly to HELD, and HELD goes directly to IDLE.
  - `Busy` duration = max(`HoldCycles`,1) cycles.
  - `BouncePairs` and `BounceHalf` are unused.

## Test plan
- Reset with `Columns`=4'b0000 held → `Rows`=4'b1111, `Busy`=0, `ScanHits`=0 on every cycle of reset and until a Press is accepted.
- Bounce enabled, defaults, `KeyCode`=4'b1001 (row 2, col 1), `HoldCycles`=10, `Columns` fixed at 4'b1101 → `Rows` toggles 4'b1011/4'b1111 every 4 cycles, 3 pairs in, 10 cycles steady 4'b1011 with `KeyDown`=1, 3 pairs out, `Busy` high for exactly 58 cycles.
- HELD with `KeyCode`=4'b0011, `Columns` rotating one-cold 1110→1101→1011→0111 every 4 clocks, `HoldCycles`=64 → `Rows`=4'b1110 only in cycles 1–4 after column 3 goes low, `ScanHits`=4 at exit.
- `Press` re-asserted while `Busy`=1 with a different `KeyCode` → ignored, and the original key completes unchanged. A `Press` in the first IDLE cycle is accepted.
- `Reset` pulsed in mid-HELD → `Rows`=4'b1111, `Busy`=0, `ScanHits`=0 on the next edge, and the next Press starts a full fresh keystroke.
- Build without `KEYPAD_EMU_BOUNCE_EN`, `HoldCycles`=0, `Columns`=4'b0000 → `Busy` high exactly 1 cycle, with `Rows` showing one active-low bit for 1 cycle, lagging by one.
